fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, instruction address width.
- INSN_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-high reset.
- jump_enable, in, 1, redirect request.
- jump_address, in, ADDR_W, redirect target.
- halt, in, 1, level; suppress new fetches.
- imem_req, out, 1, instruction memory read strobe.
- imem_addr, out, ADDR_W, read address, valid when imem_req=1.
- imem_rdata, in, INSN_W, read data; valid exactly 1 cycle after imem_req.
- if_valid, out, 1, head instruction valid to decode.
- if_ready, in, 1, decode accepts head.
- if_pc, out, ADDR_W, PC of head instruction.
- if_insn, out, INSN_W, head instruction.
- fetch_misalign, out, 1, one-cycle pulse on misaligned redirect.

REQ-003 The block SHALL have one clock, clk; reset is rst, asynchronous and active-high.

Function
REQ-004 State machine: BOOT, RUN, HALTED. Reset enters BOOT. BOOT->RUN after exactly 1 cycle. RUN->HALTED when halt=1. HALTED->RUN when halt=0.
REQ-005 Internal state:
- fetch_pc.
- 2-entry FIFO of {pc, insn}.
- inflight flag plus inflight_pc for the request issued last cycle.
REQ-006 imem_req=1 only in RUN, with jump_enable=0, and only when count + inflight - pop < 2, where pop = if_valid & if_ready.
REQ-007 On imem_req=1:
- imem_addr = fetch_pc.
- fetch_pc <= fetch_pc + 4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
- inflight <= 1; otherwise inflight <= 0.
REQ-008 When inflight=1 and no redirect is in progress this cycle, {inflight_pc, imem_rdata} SHALL be pushed into the FIFO at the clock edge.
REQ-009 if_valid = FIFO non-empty. if_pc/if_insn = FIFO head (registered; no combinational path from imem_rdata). A head entry is removed on if_valid & if_ready.
REQ-010 Throughput: 1 instruction/cycle sustained with if_ready=1. Latency from request to if_valid is 2 cycles.
REQ-011 The FIFO SHALL never overflow; no response is ever dropped except by a redirect.
REQ-012 Redirect (jump_enable=1 in cycle N), in any state except BOOT:
- A pop in cycle N completes normally.
- All other FIFO entries are flushed.
- The response arriving in N is discarded.
- imem_req=0 in N.
- fetch_pc <= {jump_address[ADDR_W-1:2], 2'b00}.
REQ-013 A redirect in HALTED SHALL update fetch_pc and flush, and remain in HALTED.
REQ-014 jump_enable in BOOT SHALL also load fetch_pc; RUN entry timing is unchanged.
REQ-015 If jump_enable=1 and jump_address[1:0]!=0, fetch_misalign=1 in cycle N+1 only. The fetch proceeds from the aligned address.
REQ-016 When halt rises, an inflight response SHALL still be pushed, and buffered entries still drain to decode.
REQ-017 if_valid, if_pc and if_insn SHALL not change while if_valid=1 and if_ready=0, unless a redirect occurs.

Reset
REQ-018 While rst=1, regardless of clk:
- State=BOOT, fetch_pc=RESET_PC.
- FIFO empty, inflight=0.
- imem_req=0, imem_addr=RESET_PC.
- if_valid=0, if_pc=0, if_insn=0, fetch_misalign=0.
REQ-019 Assertion of rst mid-operation SHALL discard all buffered and in-flight instructions immediately. Data returned after reset release for pre-reset requests SHALL be ignored.

Verification
Cycle 0 = first rising edge with rst=0.
REQ-020 Boot: RESET_PC=0, if_ready=1.
- No imem_req in cycle 0.
- imem_addr=0,4,8 in cycles 1,2,3.
- if_valid=1 with if_pc=0 in cycle 3, if_pc=4 in cycle 4.
REQ-021 Stall: if_ready=0 for 6 cycles mid-stream.
- FIFO holds exactly 2 entries; imem_req stays 0 after it fills.
- On release, if_pc values are contiguous (+4 each), with no gap or duplicate.
REQ-022 Redirect: jump_address=0x100 in cycle N, FIFO full.
- if_valid=0 in N+1 and N+2.
- imem_addr=0x100 in N+1.
- if_valid=1 with if_pc=0x100 in N+3.
REQ-023 Misaligned redirect: jump_address=0x102.
- fetch_misalign=1 in N+1 only.
- First fetched if_pc=0x100.
REQ-024 Wrap: redirect to 0xFFFF_FFFC -> imem_addr sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
REQ-025 Async reset: rst asserted between clock edges with FIFO full -> if_valid=0 and imem_req=0 immediately, before the next clock edge. Sequence after release matches REQ-020.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch front end.
//   Issues sequential reads to instruction memory, captures the one-cycle-late
//   responses into a 2-entry {pc, insn} buffer and presents the head entry to
//   decode with a valid/ready handshake. Supports redirects (jumps), halting and
//   flags misaligned redirect targets.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   jump_enable, jump_address    redirect request and target
//   halt                         level; suppresses new fetches
//   imem_req, imem_addr          memory read strobe and address
//   imem_rdata                   read data, valid one cycle after imem_req
//   if_valid, if_ready           decode handshake for the head entry
//   if_pc, if_insn               head entry contents (registered)
//   fetch_misalign               one-cycle pulse after a misaligned redirect
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_enable,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INSN_W-1:0] if_insn,
  output logic              fetch_misalign
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic [1:0]          count_q, count_d;
  logic [ADDR_W-1:0]   head_pc_q, head_pc_d;
  logic [INSN_W-1:0]   head_insn_q, head_insn_d;
  logic [ADDR_W-1:0]   tail_pc_q, tail_pc_d;
  logic [INSN_W-1:0]   tail_insn_q, tail_insn_d;
  logic                misalign_q, misalign_d;

  logic                pop;
  logic                push;
  logic                redirect;
  logic                req;
  logic [2:0]          occ;

  // Request / handshake decode
  always_comb begin
    pop      = (count_q != 2'd0) && if_ready;
    // BOOT only loads fetch_pc on a jump; the buffer is empty there anyway.
    redirect = jump_enable && (state_q != ST_BOOT);
    push     = inflight_q && !redirect;
    // Slots committed = buffered + still in flight. A new request is allowed
    // only if it is guaranteed a slot when its data returns.
    occ      = {1'b0, count_q} + {2'b00, inflight_q};
    req      = (state_q == ST_RUN) && !halt && !jump_enable &&
               (occ < (3'd2 + {2'b00, pop}));
  end

  // State machine and fetch pointer
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    misalign_d    = jump_enable && (jump_address[1:0] != 2'b00);

    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    state_d = halt ? ST_HALTED : ST_RUN;
      ST_HALTED: state_d = halt ? ST_HALTED : ST_RUN;
      default:   state_d = ST_BOOT;
    endcase

    if (req) begin
      inflight_pc_d = fetch_pc_q;
    end

    if (jump_enable) begin
      fetch_pc_d = {jump_address[ADDR_W-1:2], 2'b00};
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
  end

  // Two-slot response buffer: head is what decode sees, tail is the overflow.
  always_comb begin
    count_d     = count_q;
    head_pc_d   = head_pc_q;
    head_insn_d = head_insn_q;
    tail_pc_d   = tail_pc_q;
    tail_insn_d = tail_insn_q;

    if (redirect) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b01: begin
          head_pc_d   = tail_pc_q;
          head_insn_d = tail_insn_q;
          count_d     = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d   = inflight_pc_q;
            head_insn_d = imem_rdata;
          end else begin
            tail_pc_d   = inflight_pc_q;
            tail_insn_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          // Pop and push together: occupancy unchanged, entries shift forward.
          if (count_q == 2'd2) begin
            head_pc_d   = tail_pc_q;
            head_insn_d = tail_insn_q;
            tail_pc_d   = inflight_pc_q;
            tail_insn_d = imem_rdata;
          end else begin
            head_pc_d   = inflight_pc_q;
            head_insn_d = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Registers: control and visible head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      head_pc_q   <= '0;
      head_insn_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      head_pc_q   <= head_pc_d;
      head_insn_q <= head_insn_d;
      misalign_q  <= misalign_d;
    end
  end

  // Registers: data qualified elsewhere, no reset needed
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    tail_pc_q     <= tail_pc_d;
    tail_insn_q   <= tail_insn_d;
  end

  assign imem_req       = req;
  assign imem_addr      = fetch_pc_q;
  assign if_valid       = (count_q != 2'd0);
  assign if_pc          = head_pc_q;
  assign if_insn        = head_insn_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a
// queue-based behavioural model. Instruction memory returns a fixed function
// of the requested address one cycle after each request.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_enable = 1'b0;
  logic [31:0] jump_address = '0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        fetch_misalign;

  fetch_ctrl #(.ADDR_W(32), .INSN_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .jump_enable(jump_enable), .jump_address(jump_address), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_insn(if_insn),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  // Behavioural model
  ent_t        mq[$];
  int          m_mode;
  logic [31:0] m_pc, m_infl_pc;
  bit          m_infl, m_mis;

  // Expected outputs for the current cycle
  bit          e_req, e_valid, e_mis;
  logic [31:0] e_addr, e_pc, e_insn;

  // Memory responder state
  bit          prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF ^ {a[31:16], a[15:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = M_BOOT;
    m_pc   = 32'h0;
    m_infl = 1'b0;
    m_mis  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs after the falling edge, settle, snapshot
  // the model's expected outputs, then advance the model past the next edge.
  task automatic drive_cycle(input bit je, input logic [31:0] ja, input bit h, input bit rdy);
    bit   pop, flush;
    ent_t e;
    @(negedge clk);
    rst          = 1'b0;
    jump_enable  = je;
    jump_address = ja;
    halt         = h;
    if_ready     = rdy;
    imem_rdata   = prev_req ? mem_word(prev_addr) : $urandom;
    #1;
    e_valid = (mq.size() > 0);
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_insn  = e_valid ? mq[0].insn : 32'h0;
    pop     = e_valid && rdy;
    e_req   = (m_mode == M_RUN) && !h && !je &&
              (mq.size() + int'(m_infl) - int'(pop) < 2);
    e_addr  = m_pc;
    e_mis   = m_mis;
    prev_req  = imem_req;
    prev_addr = imem_addr;

    flush = je && (m_mode != M_BOOT);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_infl) begin
        e.pc   = m_infl_pc;
        e.insn = mem_word(m_infl_pc);
        mq.push_back(e);
      end
    end
    m_mis     = je && (ja[1:0] != 2'b00);
    m_infl_pc = m_pc;
    m_infl    = e_req;
    if (je) m_pc = {ja[31:2], 2'b00};
    else if (e_req) m_pc = m_pc + 32'd4;
    if (m_mode == M_BOOT) m_mode = M_RUN;
    else m_mode = h ? M_HALT : M_RUN;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    vectors++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    vectors++; if (if_insn !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h want 0", if_insn); end
    vectors++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", fetch_misalign); end
  endtask

  task automatic test_boot();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      vectors++; if (imem_req !== (c != 0)) begin errors++; $display("FAIL boot_req c%0d: got %b want %b", c, imem_req, (c != 0)); end
      if (c >= 1) begin
        vectors++; if (imem_addr !== 32'(4 * (c - 1))) begin errors++; $display("FAIL boot_addr c%0d: got %h want %h", c, imem_addr, 32'(4 * (c - 1))); end
      end
      vectors++; if (if_valid !== (c >= 3)) begin errors++; $display("FAIL boot_valid c%0d: got %b want %b", c, if_valid, (c >= 3)); end
      if (c >= 3) begin
        vectors++; if (if_pc !== 32'(4 * (c - 3))) begin errors++; $display("FAIL boot_pc c%0d: got %h want %h", c, if_pc, 32'(4 * (c - 3))); end
        vectors++; if (if_insn !== mem_word(32'(4 * (c - 3)))) begin errors++; $display("FAIL boot_insn c%0d: got %h want %h", c, if_insn, mem_word(32'(4 * (c - 3)))); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held, nxt;
    held = '0;
    for (int s = 0; s < 6; s++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
      if (s == 0) held = if_pc;
      vectors++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid s%0d: got %b want 1", s, if_valid); end
      vectors++; if (if_pc !== held) begin errors++; $display("FAIL stall_hold_pc s%0d: got %h want %h", s, if_pc, held); end
      vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req s%0d: got %b want 0", s, imem_req); end
    end
    nxt = held;
    for (int r = 0; r < 6; r++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      vectors++; if (if_valid !== 1'b1) begin errors++; $display("FAIL release_valid r%0d: got %b want 1", r, if_valid); end
      vectors++; if (if_pc !== nxt) begin errors++; $display("FAIL release_pc r%0d: got %h want %h", r, if_pc, nxt); end
      vectors++; if (if_insn !== mem_word(nxt)) begin errors++; $display("FAIL release_insn r%0d: got %h want %h", r, if_insn, mem_word(nxt)); end
      nxt = nxt + 32'd4;
    end
  endtask

  task automatic test_redirect();
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b0);
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_n: got %b want 0", imem_req); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n1: got %b want 0", if_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr_n1: got req %b addr %h want 1 00000100", imem_req, imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n2: got %b want 0", if_valid); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL redir_head_n3: got valid %b pc %h want 1 00000100", if_valid, if_pc); end
    vectors++; if (if_insn !== mem_word(32'h100)) begin errors++; $display("FAIL redir_insn_n3: got %h want %h", if_insn, mem_word(32'h100)); end
  endtask

  task automatic test_misalign();
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h102, 1'b0, 1'b1);
    vectors++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_n: got %b want 0", fetch_misalign); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_n1: got %b want 1", fetch_misalign); end
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mis_discard_n1: got valid %b want 0", if_valid); end
    vectors++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr_n1: got %h want 00000100", imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_n2: got %b want 0", fetch_misalign); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL mis_head_n3: got valid %b pc %h want 1 00000100", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] want_addr [3];
    want_addr[0] = 32'hFFFF_FFFC; want_addr[1] = 32'h0; want_addr[2] = 32'h4;
    drive_cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (k < 3) begin
        vectors++; if (imem_req !== 1'b1 || imem_addr !== want_addr[k]) begin errors++; $display("FAIL wrap_addr k%0d: got req %b addr %h want 1 %h", k, imem_req, imem_addr, want_addr[k]); end
      end
      if (k >= 2) begin
        vectors++; if (if_valid !== 1'b1 || if_pc !== want_addr[k-2]) begin errors++; $display("FAIL wrap_pc k%0d: got valid %b pc %h want 1 %h", k, if_valid, if_pc, want_addr[k-2]); end
      end
    end
  endtask

  task automatic test_halt();
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int h = 0; h < 6; h++) begin
      drive_cycle(h == 3, 32'h200, 1'b1, 1'b1);
      vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req h%0d: got %b want 0", h, imem_req); end
      vectors++; if (if_valid !== e_valid) begin errors++; $display("FAIL halt_valid h%0d: got %b want %b", h, if_valid, e_valid); end
      if (h == 1) begin
        vectors++; if (if_valid !== 1'b1) begin errors++; $display("FAIL halt_drain h1: got valid %b want 1", if_valid); end
      end
      if (h == 5) begin
        vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_empty h5: got valid %b want 0", if_valid); end
      end
    end
    for (int r = 0; r < 5; r++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (r == 0) begin
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL unhalt_req r0: got %b want 0", imem_req); end
      end
      if (r == 1) begin
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL unhalt_addr r1: got req %b addr %h want 1 00000200", imem_req, imem_addr); end
      end
      if (r == 3) begin
        vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL unhalt_head r3: got valid %b pc %h want 1 00000200", if_valid, if_pc); end
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (if_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", if_valid); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", if_valid); end
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL areset_req: got %b want 0", imem_req); end
    vectors++; if (if_pc !== 32'h0 || if_insn !== 32'h0) begin errors++; $display("FAIL areset_head: got pc %h insn %h want 0 0", if_pc, if_insn); end
    vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL areset_addr: got %h want 0", imem_addr); end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      vectors++; if (imem_req !== (c != 0)) begin errors++; $display("FAIL reboot_req c%0d: got %b want %b", c, imem_req, (c != 0)); end
      if (c >= 1) begin
        vectors++; if (imem_addr !== 32'(4 * (c - 1))) begin errors++; $display("FAIL reboot_addr c%0d: got %h want %h", c, imem_addr, 32'(4 * (c - 1))); end
      end
      vectors++; if (if_valid !== (c >= 3)) begin errors++; $display("FAIL reboot_valid c%0d: got %b want %b", c, if_valid, (c >= 3)); end
      if (c >= 3) begin
        vectors++; if (if_pc !== 32'(4 * (c - 3))) begin errors++; $display("FAIL reboot_pc c%0d: got %h want %h", c, if_pc, 32'(4 * (c - 3))); end
      end
    end
  endtask

  task automatic test_random();
    bit          je, h, rdy;
    logic [31:0] ja;
    h = 1'b0;
    for (int i = 0; i < 600; i++) begin
      je  = ($urandom_range(0, 15) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if ($urandom_range(0, 19) == 0) h = ~h;
      rdy = ($urandom_range(0, 3) != 0);
      drive_cycle(je, ja, h, rdy);
      vectors++; if (imem_req !== e_req) begin errors++; $display("FAIL rnd_req i%0d: got %b want %b", i, imem_req, e_req); end
      vectors++; if (imem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr i%0d: got %h want %h", i, imem_addr, e_addr); end
      vectors++; if (if_valid !== e_valid) begin errors++; $display("FAIL rnd_valid i%0d: got %b want %b", i, if_valid, e_valid); end
      vectors++; if (fetch_misalign !== e_mis) begin errors++; $display("FAIL rnd_misalign i%0d: got %b want %b", i, fetch_misalign, e_mis); end
      if (e_valid) begin
        vectors++; if (if_pc !== e_pc || if_insn !== e_insn) begin errors++; $display("FAIL rnd_head i%0d: got pc %h insn %h want %h %h", i, if_pc, if_insn, e_pc, e_insn); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_misalign();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, errors);
    $fatal(1, "time limit");
  end

endmodule
